// File: rtl/rosc_sampler_if.sv
// rosc_sampler_if -- word hand-off bus between the sampler and its consumer.
//   data       : collected 32-bit random word
//   data_valid : data holds a complete word
//   data_ack   : consumer accepts the word (ignored unless data_valid = 1)
// master = sampler side, slave = consumer side.
interface rosc_sampler_if;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ack;

    modport master (output data, output data_valid, input data_ack);
    modport slave  (input data, input data_valid, output data_ack);
endinterface

// File: rtl/rosc_sampler.sv
// rosc_sampler -- ring-oscillator entropy sampler with von Neumann debiasing.
// Seeds the oscillator, samples it every SAMPLE_DIV clocks, debiases pairs of
// samples and packs emitted bits into a 32-bit word handed off over bus.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   enable     : run request; low returns to IDLE and clears the word
//   osc_d      : raw oscillator output (asynchronous to clk)
//   osc_ctrl   : 1 = oscillator held at seed, 0 = free-running
//   osc_seed   : seed value presented while osc_ctrl = 1
//   stuck      : sticky alarm, 255 consecutive discarded pairs
//   bus        : data / data_valid / data_ack word hand-off (master side)
module rosc_sampler #(
    parameter int unsigned SEED_CYCLES = 4,
    parameter int unsigned SAMPLE_DIV  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             osc_d,
    output logic             osc_ctrl,
    output logic             osc_seed,
    output logic             stuck,
    rosc_sampler_if.master   bus
);
    typedef enum logic [1:0] {IDLE, SEED, RUN, FULL} state_t;

    localparam logic [15:0] DIV_LAST  = 16'(SAMPLE_DIV - 1);
    localparam logic [7:0]  SEED_LOAD = 8'(SEED_CYCLES);

    state_t      state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic        seed_q, seed_d;
    logic [7:0]  seed_cnt_q, seed_cnt_d;
    logic [15:0] div_q, div_d;
    logic        phase_q, phase_d;
    logic        first_q, first_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  disc_q, disc_d;
    logic        stuck_q, stuck_d;
    logic [31:0] data_q, data_d;

    // Only the second synchronizer stage is ever sampled.
    logic sample;
    assign sample = sync_q[1];

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[0], osc_d};
        seed_d     = seed_q;
        seed_cnt_d = seed_cnt_q;
        div_d      = div_q;
        phase_d    = phase_q;
        first_d    = first_q;
        bit_cnt_d  = bit_cnt_q;
        disc_d     = disc_q;
        stuck_d    = stuck_q;
        data_d     = data_q;

        if (!enable) begin
            // Dropping enable wins over everything, including data_ack.
            state_d   = IDLE;
            data_d    = '0;
            bit_cnt_d = '0;
            div_d     = '0;
            phase_d   = 1'b0;
            first_d   = 1'b0;
            disc_d    = '0;
            stuck_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = SEED;
                    seed_d     = ~seed_q;
                    seed_cnt_d = SEED_LOAD;
                end
                SEED: begin
                    seed_cnt_d = seed_cnt_q - 8'd1;
                    if (seed_cnt_q == 8'd1) begin
                        // Divider and pair phase restart on every RUN entry.
                        state_d = RUN;
                        div_d   = '0;
                        phase_d = 1'b0;
                    end
                end
                RUN: begin
                    div_d = (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
                    if (div_q == DIV_LAST) begin
                        if (!phase_q) begin
                            first_d = sample;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (sample != first_q) begin
                                data_d    = {data_q[30:0], first_q};
                                bit_cnt_d = bit_cnt_q + 6'd1;
                                disc_d    = '0;
                                if (bit_cnt_q == 6'd31) state_d = FULL;
                            end else begin
                                if (disc_q != 8'hFF) disc_d = disc_q + 8'd1;
                                if (disc_q == 8'hFE) stuck_d = 1'b1;
                            end
                        end
                    end
                end
                FULL: begin
                    if (bus.data_ack) begin
                        state_d    = SEED;
                        bit_cnt_d  = '0;
                        seed_d     = ~seed_q;
                        seed_cnt_d = SEED_LOAD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            seed_q     <= 1'b0;
            seed_cnt_q <= '0;
            div_q      <= '0;
            phase_q    <= 1'b0;
            first_q    <= 1'b0;
            bit_cnt_q  <= '0;
            disc_q     <= '0;
            stuck_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            seed_q     <= seed_d;
            seed_cnt_q <= seed_cnt_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            first_q    <= first_d;
            bit_cnt_q  <= bit_cnt_d;
            disc_q     <= disc_d;
            stuck_q    <= stuck_d;
            data_q     <= data_d;
        end
    end

    assign osc_ctrl       = (state_q == IDLE) || (state_q == SEED);
    assign osc_seed       = seed_q;
    assign stuck          = stuck_q;
    assign bus.data       = data_q;
    assign bus.data_valid = (state_q == FULL);
endmodule
